// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory arbiter: FSM states, requester indices
// and the width of the BUSY watchdog counter.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BUSY,
        ST_RELEASE
    } arb_state_e;

    localparam int unsigned REQ_PAT = 0;
    localparam int unsigned REQ_FWR = 1;
    localparam int unsigned REQ_FRD = 2;
    localparam int unsigned REQ_DMA = 3;

    localparam int unsigned TO_W = 24;

endpackage

// File: rtl/mem_arb_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first pending requester found when
// scanning upward from (last owner + 1), wrapping at N.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  pending_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] index_o,
    output logic          valid_o
);

    always_comb begin
        int unsigned k;
        grant_o = '0;
        index_o = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(last_i) + 32'd1 + i) % N;
            if (!valid_o && pending_i[k]) begin
                valid_o    = 1'b1;
                grant_o[k] = 1'b1;
                index_o    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Memory port arbiter: latches start pulses, grants one engine at a time in
// round-robin order, holds its address/size and aborts stuck transfers.
module mem_arb_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned     NREQ        = 4,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 24'hFF_FFFF
) (
    input  logic                 digiclk_i,
    input  logic                 resetn_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [32*NREQ-1:0]   req_addr_i,
    input  logic [8*NREQ-1:0]    req_size_i,
    input  logic [NREQ-1:0]      done_i,
    output logic [NREQ-1:0]      start_o,
    output logic [1:0]           owner_o,
    output logic [31:0]          mem_address_o,
    output logic [7:0]           mem_size_o,
    output logic                 busy_o,
    output logic [NREQ-1:0]      pending_o,
    output logic                 timeout_o
);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] pend_q, pend_d, pend_clr;
    logic [NREQ-1:0] start_q, start_d;
    logic [1:0]      owner_q, owner_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      size_q, size_d;
    logic            busy_q, busy_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            tout_q, tout_d;

    logic [NREQ-1:0] gnt_oh;
    logic [1:0]      gnt_idx;
    logic            gnt_vld;

    rr_arbiter #(
        .N  (NREQ),
        .IW (2)
    ) u_rr (
        .pending_i (pend_q),
        .last_i    (owner_q),
        .grant_o   (gnt_oh),
        .index_o   (gnt_idx),
        .valid_o   (gnt_vld)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        size_d   = size_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        tout_d   = tout_q;
        start_d  = '0;
        pend_clr = '0;
        unique case (state_q)
            ST_IDLE: begin
                // Grant decisions are registered so every GRANT-cycle output
                // (start, owner, address, size, busy) appears together.
                if (gnt_vld) begin
                    state_d  = ST_GRANT;
                    owner_d  = gnt_idx;
                    addr_d   = req_addr_i[32*32'(gnt_idx) +: 32];
                    size_d   = req_size_i[8*32'(gnt_idx) +: 8];
                    pend_clr = gnt_oh;
                    start_d  = gnt_oh;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            ST_GRANT: state_d = ST_BUSY;
            ST_BUSY: begin
                cnt_d = cnt_q + TO_W'(1);
                if (done_i[owner_q]) begin
                    state_d = ST_RELEASE;
                    busy_d  = 1'b0;
                end else if (cnt_d == TIMEOUT_CYC) begin
                    state_d = ST_RELEASE;
                    busy_d  = 1'b0;
                    tout_d  = 1'b1;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // A new pulse in the clearing cycle wins over the clear.
        pend_d = (pend_q & ~pend_clr) | req_i;
    end

    always_ff @(posedge digiclk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            start_q <= '0;
            owner_q <= 2'(NREQ - 1);
            addr_q  <= '0;
            size_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    assign start_o       = start_q;
    assign owner_o       = owner_q;
    assign mem_address_o = addr_q;
    assign mem_size_o    = size_q;
    assign busy_o        = busy_q;
    assign pending_o     = pend_q;
    assign timeout_o     = tout_q;

endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (index 0 = pattern init/test, 1 = DIGIFIFO write, 2 = MEMFIFO read, 3 = LSRAM->DDR3 DMA).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 24'hFF_FFFF, maximum BUSY cycles before abort.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 port digiclk_i  input  1  sole clock; all logic on rising edge.
REQ-005 port resetn_i  input  1  asynchronous active-low reset.
REQ-006 port req_i  input  NREQ  single-cycle start pulses, one bit per requester.
REQ-007 port req_addr_i  input  32*NREQ  per-requester memory start address, slice k = [32k+31:32k].
REQ-008 port req_size_i  input  8*NREQ  per-requester burst count, slice k = [8k+7:8k].
REQ-009 port done_i  input  NREQ  completion pulse from each requester's engine.
REQ-010 port start_o  output  NREQ  one-hot single-cycle start to granted engine.
REQ-011 port owner_o  output  2  index of current/last owner.
REQ-012 port mem_address_o  output  32  latched address of granted request.
REQ-013 port mem_size_o  output  8  latched size of granted request.
REQ-014 port busy_o  output  1  high from grant until done/abort.
REQ-015 port pending_o  output  NREQ  latched, not yet served requests.
REQ-016 port timeout_o  output  1  sticky abort flag; cleared only by reset.

Function
REQ-017 A req_i[k] pulse SHALL set pending[k] on the next edge; a repeated pulse while pending[k]=1 SHALL be absorbed (no queue depth >1).
REQ-018 FSM states SHALL be IDLE, GRANT, BUSY, RELEASE.
REQ-019 IDLE -> GRANT when any pending bit set; winner chosen round-robin starting at (last owner + 1) mod NREQ.
REQ-020 In GRANT (1 cycle), owner_o, mem_address_o and mem_size_o SHALL load from winner's slices, pending[winner] SHALL clear, start_o[winner] SHALL pulse one cycle, busy_o SHALL rise; next state BUSY.
REQ-021 mem_address_o/mem_size_o SHALL hold constant from GRANT until next GRANT, regardless of req_addr_i changes.
REQ-022 In BUSY, done_i[owner] SHALL move FSM to RELEASE; done_i of non-owners SHALL be ignored.
REQ-023 In BUSY, a 24-bit counter SHALL increment each cycle; on reaching TIMEOUT_CYC without done, timeout_o SHALL set and FSM SHALL go to RELEASE.
REQ-024 RELEASE (1 cycle) SHALL drop busy_o and return to IDLE; start-to-start minimum spacing is therefore 3 cycles after done.
REQ-025 req_i[k] arriving in the same cycle pending[k] clears in GRANT SHALL re-set pending[k] (set wins).
REQ-026 req_i[owner] during BUSY SHALL become pending and be served after any other pending requesters in round-robin order.
REQ-027 mem_size_o = 0 SHALL still be granted; completion relies on done_i or timeout.
REQ-028 start_o SHALL never have more than one bit set.

Reset
REQ-029 On resetn_i low, asynchronously: FSM=IDLE, pending=0, start_o=0, busy_o=0, owner_o=NREQ-1 (so requester 0 wins first), mem_address_o=0, mem_size_o=0, timeout counter=0, timeout_o=0.
REQ-030 Reset asserted mid-BUSY SHALL abort without any start_o or extra pulse; in-flight engine state is not this block's responsibility.

Structure
REQ-031 State encoding, requester index constants (REQ_PAT, REQ_FWR, REQ_FRD, REQ_DMA) and timeout width SHALL live in a shared package mem_ctrl_pkg.
REQ-032 Round-robin priority selection SHALL be one sub-module rr_arbiter (inputs pending, last owner; outputs one-hot grant, index, valid), purely combinational.

Verification
REQ-033 Reset release, req_i=4'b0001, addr0=32'h2000_0400, size0=8'd16 -> start_o=4'b0001 two cycles later, mem_address_o=32'h2000_0400, mem_size_o=16, busy_o=1 until 1 cycle after done_i[0].
REQ-034 req_i=4'b1111 simultaneously from IDLE, done returned 5 cycles after each start -> start order 0,1,2,3; pending_o steps 1110,1100,1000,0000.
REQ-035 While owner=1 BUSY, pulse done_i[2] -> no state change; then done_i[1] -> RELEASE, busy_o low next cycle.
REQ-036 TIMEOUT_CYC=16, grant requester 3, never return done -> timeout_o=1 after 16 BUSY cycles, busy_o falls, pending requester 0 granted next; timeout_o stays 1.
REQ-037 req_i[2] pulsed twice during another owner's BUSY -> exactly one start_o[2] pulse.
REQ-038 resetn_i low for 1 cycle mid-BUSY with pending=4'b0110 -> all outputs at reset values, no start_o until new req_i.
